// File: rtl/programmable_updown_counter.sv
// Parametrised up/down counter with modulo limit, wrap/saturate modes,
// registered terminal-count pulse, sticky saturation flag and tri-state output.
module programmable_updown_counter #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             up_dn,
    input  logic             sat,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] limit,
    input  logic             oe_n,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             sat_hit
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             sat_hit_nxt;

    always_comb begin
        cnt_nxt     = cnt;
        tc_nxt      = 1'b0;
        sat_hit_nxt = sat_hit;
        if (load) begin
            cnt_nxt     = data;
            sat_hit_nxt = 1'b0;
        end else if (en) begin
            if (up_dn) begin
                // >= so that a value loaded above limit is treated as the boundary
                if (cnt < limit) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (!sat) begin
                    cnt_nxt = '0;
                    tc_nxt  = 1'b1;
                end else begin
                    sat_hit_nxt = 1'b1;
                end
            end else begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (!sat) begin
                    cnt_nxt = limit;
                    tc_nxt  = 1'b1;
                end else begin
                    sat_hit_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= RESET_VALUE;
            tc      <= 1'b0;
            sat_hit <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            tc      <= tc_nxt;
            sat_hit <= sat_hit_nxt;
        end
    end

    assign count = oe_n ? {WIDTH{1'bz}} : cnt;

endmodule

// File: tb/tb_programmable_updown_counter.sv
// Directed-vector bench for programmable_updown_counter (WIDTH=8).
// The count pin is pulled up so a released bus reads as all ones.
module tb_programmable_updown_counter;

    logic       clk = 1'b0;
    logic       reset, en, load, up_dn, sat, oe_n;
    logic [7:0] data, limit;
    tri1  [7:0] count;
    logic       tc, sat_hit;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic       reset, load, en, up_dn, sat, oe_n;
        logic [7:0] data, limit;
        logic [7:0] ec;
        logic       etc, esh;
    } vec_t;

    vec_t tbl[$];

    programmable_updown_counter #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .up_dn(up_dn),
        .sat(sat), .data(data), .limit(limit), .oe_n(oe_n),
        .count(count), .tc(tc), .sat_hit(sat_hit)
    );

    always #5 clk = ~clk;

    task automatic add(string nm, logic r, logic l, logic e, logic u,
                       logic s, logic o, logic [7:0] d, logic [7:0] lim,
                       logic [7:0] ec, logic etc, logic esh);
        vec_t v;
        v.name = nm; v.reset = r; v.load = l; v.en = e; v.up_dn = u;
        v.sat = s; v.oe_n = o; v.data = d; v.limit = lim;
        v.ec = ec; v.etc = etc; v.esh = esh;
        tbl.push_back(v);
    endtask

    task automatic step(logic r, logic l, logic e, logic u, logic s,
                        logic o, logic [7:0] d, logic [7:0] lim);
        @(negedge clk);
        reset = r; load = l; en = e; up_dn = u; sat = s; oe_n = o;
        data = d; limit = lim;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [7:0] ec, logic etc, logic esh);
        n_vec++;
        if (count !== ec || tc !== etc || sat_hit !== esh) begin
            n_bad++;
            $display("FAIL %s: got count=%h tc=%b sat_hit=%b, want %h %b %b",
                     nm, count, tc, sat_hit, ec, etc, esh);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; en = 1'b0; up_dn = 1'b1; sat = 1'b0;
        oe_n = 1'b0; data = 8'h00; limit = 8'hFF;

        // name, reset, load, en, up_dn, sat, oe_n, data, limit, count, tc, sat_hit
        add("mod_load",     0,1,0,1,0,0, 8'h07, 8'd9,  8'd7,  0,0);
        add("mod_up8",      0,0,1,1,0,0, 8'h00, 8'd9,  8'd8,  0,0);
        add("mod_up9",      0,0,1,1,0,0, 8'h00, 8'd9,  8'd9,  0,0);
        add("mod_wrap",     0,0,1,1,0,0, 8'h00, 8'd9,  8'd0,  1,0);
        add("mod_up1",      0,0,1,1,0,0, 8'h00, 8'd9,  8'd1,  0,0);
        add("dn_load",      0,1,0,0,0,0, 8'h01, 8'd5,  8'd1,  0,0);
        add("dn_0",         0,0,1,0,0,0, 8'h00, 8'd5,  8'd0,  0,0);
        add("dn_wrap",      0,0,1,0,0,0, 8'h00, 8'd5,  8'd5,  1,0);
        add("dn_4",         0,0,1,0,0,0, 8'h00, 8'd5,  8'd4,  0,0);
        add("ds_load",      0,1,0,0,1,0, 8'h01, 8'd5,  8'd1,  0,0);
        add("ds_0",         0,0,1,0,1,0, 8'h00, 8'd5,  8'd0,  0,0);
        add("ds_hold1",     0,0,1,0,1,0, 8'h00, 8'd5,  8'd0,  0,1);
        add("ds_hold2",     0,0,1,0,1,0, 8'h00, 8'd5,  8'd0,  0,1);
        add("ds_en0",       0,0,0,0,1,0, 8'h00, 8'd5,  8'd0,  0,1);
        add("pri_load",     0,1,1,1,1,0, 8'h3C, 8'h3C, 8'h3C, 0,0);
        add("pri_sat",      0,0,1,1,1,0, 8'h00, 8'h3C, 8'h3C, 0,1);
        add("pri_rst_load", 1,1,1,1,1,0, 8'h55, 8'h3C, 8'h00, 0,0);
        add("lim0_a",       0,0,1,1,0,0, 8'h00, 8'h00, 8'h00, 1,0);
        add("lim0_b",       0,0,1,1,0,0, 8'h00, 8'h00, 8'h00, 1,0);
        add("rst_load2",    1,1,1,1,0,0, 8'h77, 8'h00, 8'h00, 0,0);
        add("lim0_sat",     0,0,1,1,1,0, 8'h00, 8'h00, 8'h00, 0,1);
        add("en0_load",     0,1,0,1,0,0, 8'h21, 8'hFF, 8'h21, 0,0);
        add("en0_a",        0,0,0,1,0,0, 8'h00, 8'hFF, 8'h21, 0,0);
        add("en0_b",        0,0,0,0,0,0, 8'h00, 8'hFF, 8'h21, 0,0);
        add("en0_c",        0,0,0,1,1,0, 8'h00, 8'hFF, 8'h21, 0,0);
        add("above_load",   0,1,0,1,0,0, 8'd20, 8'd10, 8'd20, 0,0);
        add("above_up",     0,0,1,1,0,0, 8'h00, 8'd10, 8'd0,  1,0);
        add("above_load2",  0,1,0,1,0,0, 8'd20, 8'd10, 8'd20, 0,0);
        add("above_dn",     0,0,1,0,0,0, 8'h00, 8'd10, 8'd19, 0,0);
        add("limchg_load",  0,1,0,1,0,0, 8'd8,  8'd9,  8'd8,  0,0);
        add("limchg_hold",  0,0,0,1,0,0, 8'h00, 8'd3,  8'd8,  0,0);
        add("limchg_up",    0,0,1,1,0,0, 8'h00, 8'd3,  8'd0,  1,0);

        repeat (2) @(posedge clk);
        #1;
        check("reset", 8'h00, 1'b0, 1'b0);

        // Free-running count through a full 8-bit wrap
        for (int i = 1; i <= 256; i++) begin
            step(0, 0, 1, 1, 0, 0, 8'h00, 8'hFF);
            check($sformatf("free_%0d", i), 8'(i), (i == 256), 1'b0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].reset, tbl[i].load, tbl[i].en, tbl[i].up_dn,
                 tbl[i].sat, tbl[i].oe_n, tbl[i].data, tbl[i].limit);
            check(tbl[i].name, tbl[i].ec, tbl[i].etc, tbl[i].esh);
        end

        // Released bus keeps counting internally
        step(0, 1, 0, 1, 0, 0, 8'h0A, 8'hFF);
        check("tri_load", 8'h0A, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 1, 0, 1, 8'h00, 8'hFF);
            check($sformatf("tri_z_%0d", i), 8'hFF, 1'b0, 1'b0);
        end
        step(0, 0, 0, 1, 0, 0, 8'h00, 8'hFF);
        check("tri_resume", 8'h0E, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
